exp_mu_collector: RTL
=====================

# exp_mu_collector

Downstream stage of the exp(mu) generator. It captures the generator's (data, address, valid, done) sample stream into a 512×18 on-chip table and keeps a running sum and sample count. After the stream completes, it serves random-access reads of the table to the later risk-aggregation stages. It also flags address-sequence errors so that truncated or reordered generator output is detected and not silently used.

## Interface
- DATA_W, 18, sample width (unsigned, same fixed-point format as generator output)
- ADDR_W, 9, table address width; depth = 2^ADDR_W = 512
- SUM_W, DATA_W+ADDR_W = 27, accumulator width; cannot overflow
- CLK  in  1  system clock, rising edge
- iRst_n  in  1  synchronous active-low reset
- iStart  in  1  one-cycle pulse; clears state and arms collection (same pulse that starts the generator)
- iData  in  DATA_W  sample from generator
- iAddr  in  ADDR_W  sample index from generator
- iValid  in  1  sample qualifier
- iDone  in  1  generator end-of-stream pulse
- iRdAddr  in  ADDR_W  table read address
- oRdData  out  DATA_W  table read data, 1-cycle latency
- oSum  out  SUM_W  sum of accepted samples
- oCount  out  ADDR_W+1  number of accepted samples (0..512)
- oBusy  out  1  collection in progress
- oReady  out  1  table/sum complete and valid
- oErr  out  1  sticky sequence error for the current run

## Operation
- States: IDLE, COLLECT, DONE.
- IDLE: all iValid/iDone ignored. iStart -> COLLECT; sum, count, expected address and oErr are cleared in the same edge.
- COLLECT, on iValid:
  - write iData to table[iAddr]; sum += iData; count += 1; expected address += 1.
  - If iAddr != expected address, set oErr. The sample is still stored and summed.
- COLLECT, on iDone -> DONE. If iValid and iDone are in the same cycle, the sample is accepted first, then the transition happens.
- COLLECT, iValid while count == 512: the sample is not written or summed, oErr is set, and count saturates at 512.
- DONE: holds sum, count and oErr. iValid/iDone ignored. iStart -> COLLECT with a full clear.
- iStart in COLLECT restarts the run: clear, remain in COLLECT. An iValid in the same cycle is dropped, because clear takes priority.
- At DONE entry, if count != 512, set oErr.
- Table read port is available in every state:
  - oRdData = table[iRdAddr] registered.
  - Write and read of the same address in the same cycle returns the old data (read-first).
- Table contents are not cleared by reset or iStart. Consumers qualify reads with oReady.
- Arithmetic is unsigned. Sum is zero-extended to SUM_W, with no saturation needed (512 × (2^18−1) < 2^27).

## Timing
- Reset (iRst_n low at the edge): state IDLE, oSum 0, oCount 0, oBusy 0, oReady 0, oErr 0. oRdData is undefined until the first read after reset. Reset overrides iStart.
- oBusy = (state == COLLECT). It is high the cycle after iStart is sampled.
- A sample accepted at edge N is reflected in oSum/oCount after edge N, and is readable via the table from edge N+1 (read issued at N+1, data visible after N+2).
- oReady is high the cycle after iDone is sampled, stays high until the next iStart or reset, and drops in the same edge as the clear.
- oErr is sticky within a run and clears only on iStart or reset.
- No back-pressure: one sample is accepted per cycle at full rate.

## Structure
- Shared package (exp_mu_pkg): DATA_W, ADDR_W, SUM_W, TABLE_DEPTH, state enum {IDLE, COLLECT, DONE}. The generator uses the same width constants.
- One sub-module: exp_table_ram, a simple dual-port 512×18 RAM (one write port, one registered read port, read-first), written to infer block RAM.
- FSM, accumulator, counter and error checker live in the top module.

## Test plan
- Nominal run:
  - Stimulus: reset, iStart, 512 back-to-back samples with iData = addr+1 and iAddr 0..511, then iDone.
  - Required: oReady=1, oCount=512, oSum=131328, oErr=0. Reading addresses 0/255/511 returns 1/256/512 with 1-cycle latency.
- Same-cycle valid+done:
  - Stimulus: last sample (addr 511, data 7) arrives with iDone.
  - Required: it is counted (oCount=512, sum includes 7) and oReady rises next cycle.
- Sequence error:
  - Stimulus: addresses 0,1,3,… (2 skipped), stream truncated to 511 samples.
  - Required: oErr=1 after addr 3 is accepted, oCount=511 at DONE, table[3] holds the sample.
- Overflow:
  - Stimulus: 513 valid samples before iDone.
  - Required: oCount stays 512, the 513th sample is not summed, oErr=1.
- Restart mid-run:
  - Stimulus: iStart after 100 samples with an iValid in the same cycle.
  - Required: oSum=0, oCount=0, oBusy=1 next cycle, and that sample is dropped.
- Reset mid-run:
  - Stimulus: iRst_n low during COLLECT.
  - Required: all outputs at reset values next cycle, and subsequent iValid/iDone are ignored until iStart.

Source files
------------

// File: rtl/exp_mu_pkg.sv
// Shared widths and state encoding for the exp(mu) generator and its collector.
// Constants only: no logic, no latency, no flow control.
package exp_mu_pkg;

    localparam int DATA_W      = 18;
    localparam int ADDR_W      = 9;
    localparam int SUM_W       = DATA_W + ADDR_W;
    localparam int TABLE_DEPTH = 1 << ADDR_W;

    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(TABLE_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/exp_table_ram.sv
// Simple dual-port sample table: one write port and one read-first registered read port.
// Read data appears one cycle after the address; no back-pressure, one access per port per cycle.
module exp_table_ram
    import exp_mu_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [TABLE_DEPTH];

    // Reading the array before the write lands gives old data on an address collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/exp_mu_collector.sv
// Captures the exp(mu) sample stream into a table, tracks sum/count, flags sequence errors.
// Samples reflected in sum/count one edge after acceptance; table reads have 1-cycle latency; no back-pressure.
module exp_mu_collector
    import exp_mu_pkg::*;
(
    input  logic              CLK,
    input  logic              iRst_n,
    input  logic              iStart,
    input  logic [DATA_W-1:0] iData,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic              iValid,
    input  logic              iDone,
    input  logic [ADDR_W-1:0] iRdAddr,
    output logic [DATA_W-1:0] oRdData,
    output logic [SUM_W-1:0]  oSum,
    output logic [ADDR_W:0]   oCount,
    output logic              oBusy,
    output logic              oReady,
    output logic              oErr
);

    state_t            state;
    state_t            state_nxt;
    logic [SUM_W-1:0]  sum;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_nxt;
    logic [ADDR_W-1:0] exp_addr;
    logic              err;

    logic collecting;
    logic full;
    logic accept;
    logic overflow_hit;
    logic seq_bad;
    logic finish;
    logic short_run;

    // A start pulse in COLLECT restarts the run and swallows any same-cycle sample or done.
    always_comb begin
        collecting   = (state == COLLECT);
        full         = (count == COUNT_MAX);
        accept       = collecting && iValid && !iStart && !full;
        overflow_hit = collecting && iValid && !iStart && full;
        seq_bad      = accept && (iAddr != exp_addr);
        finish       = collecting && iDone && !iStart;
        count_nxt    = count + {{ADDR_W{1'b0}}, accept};
        short_run    = finish && (count_nxt != COUNT_MAX);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iStart) state_nxt = COLLECT;
            COLLECT: if (!iStart && iDone) state_nxt = DONE;
            DONE:    if (iStart) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!iRst_n) begin
            sum      <= '0;
            count    <= '0;
            exp_addr <= '0;
            err      <= 1'b0;
        end else if (iStart) begin
            sum      <= '0;
            count    <= '0;
            exp_addr <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                sum      <= sum + SUM_W'(iData);
                count    <= count_nxt;
                exp_addr <= exp_addr + 1'b1;
            end
            if (seq_bad || overflow_hit || short_run) begin
                err <= 1'b1;
            end
        end
    end

    exp_table_ram u_table (
        .clk     (CLK),
        .wr_en   (accept && iRst_n),
        .wr_addr (iAddr),
        .wr_data (iData),
        .rd_addr (iRdAddr),
        .rd_data (oRdData)
    );

    assign oSum   = sum;
    assign oCount = count;
    assign oBusy  = (state == COLLECT);
    assign oReady = (state == DONE);
    assign oErr   = err;

endmodule
